// File: rtl/rv64_pkg.sv
// Shared RV64I-Zba pipeline definitions: datapath widths, the canonical NOP
// and the {pc, instr} packet carried from fetch to decode.
package rv64_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle. The slave side is the queue itself; the
// master side is the surrounding pipeline (fetch producer plus decode consumer).
interface fetch_queue_if;
    import rv64_pkg::*;

    logic [XLEN-1:0] PC_F;
    logic [ILEN-1:0] Instr_F;
    logic            Valid_F;
    logic            Ready_F;
    logic            Flush;
    logic [XLEN-1:0] PC_D;
    logic [XLEN-1:0] PCPlus4_D;
    logic [ILEN-1:0] Instr_D;
    logic            Valid_D;
    logic            Ready_D;

    modport master (
        output PC_F, Instr_F, Valid_F, Flush, Ready_D,
        input  Ready_F, PC_D, PCPlus4_D, Instr_D, Valid_D
    );

    modport slave (
        input  PC_F, Instr_F, Valid_F, Flush, Ready_D,
        output Ready_F, PC_D, PCPlus4_D, Instr_D, Valid_D
    );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Generic circular FIFO with synchronous clear; the read port is the array
// entry addressed by the registered read pointer, so dout has no input path.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) mem[wptr] <= din;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch/decode decoupling queue: buffers {PC, instr} pairs, presents the
// oldest to decode, and substitutes PC 0 / NOP whenever nothing is held.
module fetch_queue
    import rv64_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave bus
);

    fetch_pkt_t      in_pkt;
    fetch_pkt_t      head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] pc_d;

    // Flush wins over both handshakes, so a redirect never leaks an entry.
    assign push   = bus.Valid_F && !full && !bus.Flush;
    assign pop    = !empty && bus.Ready_D && !bus.Flush;
    assign in_pkt = '{pc: bus.PC_F, instr: bus.Instr_F};

    sync_fifo #(
        .WIDTH($bits(fetch_pkt_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .clear(bus.Flush),
        .din  (in_pkt),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    assign pc_d          = empty ? '0 : head.pc;
    assign bus.Ready_F   = !full;
    assign bus.Valid_D   = !empty;
    assign bus.PC_D      = pc_d;
    assign bus.Instr_D   = empty ? NOP_INSTR : head.instr;
    assign bus.PCPlus4_D = pc_d + XLEN'(4);

endmodule
